muldiv_sequencer: RTL and testbench

Controller for the shared iterative multiply/divide unit used by both execute lanes. It arbitrates M-extension requests from exec lane 0 and exec lane 1, and sequences the single unit through a start/done handshake. It resolves divide-by-zero and signed overflow without using the unit. It holds `exec_stall_o` high until every requesting lane in the current execute pair has a captured result, and those results stay stable until the backend advances.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if
//   Handshake bundle between the mul/div sequencer and the shared iterative
//   multiply/divide unit.
//   Signals:
//     start  - one-cycle start pulse (sequencer -> unit)
//     kill   - one-cycle abort pulse (sequencer -> unit)
//     op     - registered funct3 for the unit
//     a, b   - registered operands for the unit
//     done   - one-cycle pulse, result is valid (unit -> sequencer)
//     result - unit result (unit -> sequencer)
//   Modports: master = sequencer side, slave = unit side.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, kill, op, a, b, input done, result);
  modport slave  (input start, kill, op, a, b, output done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Controller for the shared iterative multiply/divide unit. Arbitrates
//   M-extension ops from exec lane 0 and lane 1 (lane 0 first), issues them
//   to the unit through a start/done handshake, resolves divide-by-zero and
//   signed-overflow cases locally, and stalls execute until every requesting
//   lane of the current pair has a captured result.
//   Ports:
//     clock_i, reset_ni       - clock, asynchronous active-low reset
//     backend_we_i            - pipeline advance, clears the per-lane done flags
//     flush_i                 - abort in-flight op, clear done flags
//     req0_i/req1_i           - lane holds a mul/div op in execute
//     op0_i/op1_i             - funct3 of the lane op
//     a0_i,b0_i,a1_i,b1_i     - lane operands
//     unit                    - handshake to the shared unit (master side)
//     result0_o/result1_o     - captured lane results
//     exec_stall_o            - combinational stall request
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  backend_we_i,
  input  logic                  flush_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic [2:0]            op0_i,
  input  logic [2:0]            op1_i,
  input  logic [XLEN-1:0]       a0_i,
  input  logic [XLEN-1:0]       b0_i,
  input  logic [XLEN-1:0]       a1_i,
  input  logic [XLEN-1:0]       b1_i,
  muldiv_sequencer_if.master    unit,
  output logic [XLEN-1:0]       result0_o,
  output logic [XLEN-1:0]       result1_o,
  output logic                  exec_stall_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_reg, state_next;
  logic            owner_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] a_reg, b_reg;

  logic [1:0]      req, pend, done_flags, cap;
  logic [2:0]      op_lane [2];
  logic [XLEN-1:0] a_lane [2], b_lane [2], result_lane [2];

  logic            sel;
  logic [2:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b, special_result, cap_value;
  logic            b_zero, ovf, special;
  logic            start_comb, kill_comb, load;

  assign req        = {req1_i, req0_i};
  assign op_lane[0] = op0_i;
  assign op_lane[1] = op1_i;
  assign a_lane[0]  = a0_i;
  assign a_lane[1]  = a1_i;
  assign b_lane[0]  = b0_i;
  assign b_lane[1]  = b1_i;

  // Per-lane done flag and result register. A capture beats the done-flag
  // clear from backend_we/flush; results survive backend_we.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic            done_reg;
      logic [XLEN-1:0] result_reg;

      assign pend[gi]        = req[gi] & ~done_reg;
      assign done_flags[gi]  = done_reg;
      assign result_lane[gi] = result_reg;

      always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
          done_reg   <= 1'b0;
          result_reg <= '0;
        end else if (cap[gi]) begin
          done_reg   <= 1'b1;
          result_reg <= cap_value;
        end else if (flush_i || backend_we_i) begin
          done_reg   <= 1'b0;
        end
      end
    end
  endgenerate

  // Lane 0 has priority whenever it still needs a result.
  assign sel    = ~pend[0];
  assign sel_op = op_lane[sel];
  assign sel_a  = a_lane[sel];
  assign sel_b  = b_lane[sel];

  // Ops 4..7 are divides; op[0]==0 marks the signed ones, op[1]==1 the remainders.
  assign b_zero  = (sel_b == '0);
  assign ovf     = ~sel_op[0] & (sel_a == MIN_INT) & (&sel_b);
  assign special = sel_op[2] & (b_zero | ovf);

  always_comb begin
    special_result = '0;
    if (b_zero) special_result = sel_op[1] ? sel_a : '1;
    else        special_result = sel_op[1] ? '0 : MIN_INT;
  end

  always_comb begin
    state_next = state_reg;
    start_comb = 1'b0;
    kill_comb  = 1'b0;
    load       = 1'b0;
    cap        = 2'b00;
    cap_value  = '0;
    if (flush_i) begin
      // A done arriving alongside the flush is dropped with the op.
      state_next = IDLE;
      kill_comb  = (state_reg == BUSY);
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pend) begin
            if (special) begin
              cap[sel]  = 1'b1;
              cap_value = special_result;
            end else begin
              start_comb = 1'b1;
              load       = 1'b1;
              state_next = BUSY;
            end
          end
        end
        BUSY: begin
          if (unit.done) begin
            cap[owner_reg] = 1'b1;
            cap_value      = unit.result;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        owner_reg <= sel;
        op_reg    <= sel_op;
        a_reg     <= sel_a;
        b_reg     <= sel_b;
      end
    end
  end

  // Pulses are masked while reset is held so outputs read zero without a clock.
  assign unit.start   = start_comb & reset_ni;
  assign unit.kill    = kill_comb & reset_ni;
  assign unit.op      = op_reg;
  assign unit.a       = a_reg;
  assign unit.b       = b_reg;

  assign result0_o    = result_lane[0];
  assign result1_o    = result_lane[1];
  assign exec_stall_o = |(req & ~done_flags);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
//   Self-checking bench for muldiv_sequencer. The bench plays the shared
//   unit (fixed latency, result from an arithmetic reference) and checks
//   lane results, stall length and unit handshake against a RISC-V M-ext
//   reference model.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        backend_we_i = 1'b0, flush_i = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0;
  logic [2:0]  op0_i = '0, op1_i = '0;
  logic [31:0] a0_i = '0, b0_i = '0, a1_i = '0, b1_i = '0;
  logic [31:0] result0_o, result1_o;
  logic        exec_stall_o;

  muldiv_sequencer_if #(.XLEN(XLEN)) uif ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni), .backend_we_i(backend_we_i), .flush_i(flush_i),
    .req0_i(req0_i), .req1_i(req1_i), .op0_i(op0_i), .op1_i(op1_i),
    .a0_i(a0_i), .b0_i(b0_i), .a1_i(a1_i), .b1_i(b1_i),
    .unit(uif), .result0_o(result0_o), .result1_o(result1_o), .exec_stall_o(exec_stall_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0, errors = 0;
  int unit_lat = 4;
  logic force_done = 1'b0;
  int unit_cnt;
  int cyc = 0, start_cnt = 0, kill_cnt = 0;
  logic start_q = 1'b0;
  logic [31:0] exp0 = '0, exp1 = '0;

  typedef struct {logic [2:0] op; logic [31:0] a; logic [31:0] b;} start_t;
  start_t start_log[$];
  int     start_cyc[$];

  // Reference M-extension semantics.
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return 32'(ua / ub); end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin if (b == 0) return a; return 32'(ua % ub); end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // Unit model: done pulses unit_lat cycles after the start cycle.
  assign uif.done   = (unit_cnt == 1) | force_done;
  assign uif.result = ref_op(uif.op, uif.a, uif.b);

  always @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni)            unit_cnt <= 0;
    else if (uif.kill)        unit_cnt <= 0;
    else if (uif.start)       unit_cnt <= unit_lat;
    else if (unit_cnt > 0)    unit_cnt <= unit_cnt - 1;
  end

  always @(posedge clock_i) begin
    cyc     <= cyc + 1;
    start_q <= uif.start;
    if (uif.start) begin
      start_cnt <= start_cnt + 1;
      start_cyc.push_back(cyc);
    end
    if (uif.kill) kill_cnt <= kill_cnt + 1;
  end

  always @(negedge clock_i) begin
    if (start_q) start_log.push_back('{uif.op, uif.a, uif.b});
  end

  task automatic set_lanes(input logic r0, input logic [2:0] o0, input logic [31:0] x0, input logic [31:0] y0,
                           input logic r1, input logic [2:0] o1, input logic [31:0] x1, input logic [31:0] y1);
    req0_i = r0; op0_i = o0; a0_i = x0; b0_i = y0;
    req1_i = r1; op1_i = o1; a1_i = x1; b1_i = y1;
  endtask

  // Counts cycles with the stall high, bounded by max.
  task automatic wait_stall(input int max, output int n);
    #1;
    n = 0;
    while (exec_stall_o && n < max) begin
      n++;
      @(negedge clock_i);
    end
  endtask

  task automatic end_pair();
    req0_i = 1'b0; req1_i = 1'b0; backend_we_i = 1'b1;
    @(negedge clock_i);
    backend_we_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock_i);
    checks++; if (result0_o !== 32'h0) begin errors++; $display("FAIL reset_result0: got %h want 0", result0_o); end
    checks++; if (result1_o !== 32'h0) begin errors++; $display("FAIL reset_result1: got %h want 0", result1_o); end
    checks++; if (uif.start !== 1'b0 || uif.kill !== 1'b0) begin errors++; $display("FAIL reset_pulses: start %b kill %b want 0 0", uif.start, uif.kill); end
    checks++; if (uif.op !== 3'h0 || uif.a !== 32'h0 || uif.b !== 32'h0) begin errors++; $display("FAIL reset_unit_regs: op %h a %h b %h want 0", uif.op, uif.a, uif.b); end
    checks++; if (exec_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", exec_stall_o); end
    set_lanes(1, 3'd0, 32'd1, 32'd1, 0, 3'd0, 0, 0);
    #1;
    checks++; if (exec_stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_follows: got %b want 1", exec_stall_o); end
    checks++; if (uif.start !== 1'b0) begin errors++; $display("FAIL reset_no_start: got %b want 0", uif.start); end
    req0_i = 1'b0;
    @(negedge clock_i);
    reset_ni = 1'b1;
    @(negedge clock_i);
  endtask

  task automatic test_single_mul();
    int n, s, i;
    unit_lat = 4; s = start_cnt; i = start_log.size();
    set_lanes(1, 3'd0, 32'd7, 32'd6, 0, 3'd0, 0, 0);
    wait_stall(40, n);
    $display("txn single: lane0 MUL 7*6 stall=%0d result0=%0d", n, result0_o);
    checks++; if (n != 5) begin errors++; $display("FAIL single_stall: got %0d want 5", n); end
    checks++; if (start_cnt - s != 1) begin errors++; $display("FAIL single_starts: got %0d want 1", start_cnt - s); end
    checks++; if (start_log.size() != i + 1) begin errors++; $display("FAIL single_log: got %0d want %0d", start_log.size(), i + 1); end
    else begin
      checks++; if (start_log[i].op !== 3'd0 || start_log[i].a !== 32'd7 || start_log[i].b !== 32'd6) begin
        errors++; $display("FAIL single_operands: op %0d a %0d b %0d want 0 7 6", start_log[i].op, start_log[i].a, start_log[i].b); end
    end
    exp0 = 32'd42;
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL single_result: got %0d want %0d", result0_o, exp0); end
    end_pair();
  endtask

  task automatic test_two_lanes();
    int n, s, i;
    unit_lat = 4; s = start_cnt; i = start_cyc.size();
    set_lanes(1, 3'd0, 32'd3, 32'd5, 1, 3'd5, 32'd100, 32'd7);
    wait_stall(40, n);
    $display("txn two_lanes: stall=%0d result0=%0d result1=%0d", n, result0_o, result1_o);
    checks++; if (n != 10) begin errors++; $display("FAIL two_stall: got %0d want 10", n); end
    checks++; if (start_cnt - s != 2) begin errors++; $display("FAIL two_starts: got %0d want 2", start_cnt - s); end
    else begin
      checks++; if (start_cyc[i+1] - start_cyc[i] != 5) begin errors++; $display("FAIL two_start_gap: got %0d want 5", start_cyc[i+1] - start_cyc[i]); end
    end
    exp0 = 32'd15; exp1 = 32'd14;
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL two_result0: got %0d want %0d", result0_o, exp0); end
    checks++; if (result1_o !== exp1) begin errors++; $display("FAIL two_result1: got %0d want %0d", result1_o, exp1); end
    end_pair();
  endtask

  task automatic test_special();
    int n, s;
    s = start_cnt;
    set_lanes(1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 3'd4, 32'd9, 32'd0);
    wait_stall(40, n);
    $display("txn special: stall=%0d result0=%h result1=%h", n, result0_o, result1_o);
    checks++; if (n != 2) begin errors++; $display("FAIL special_stall: got %0d want 2", n); end
    checks++; if (start_cnt - s != 0) begin errors++; $display("FAIL special_starts: got %0d want 0", start_cnt - s); end
    exp0 = 32'h0; exp1 = 32'hFFFF_FFFF;
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL special_result0: got %h want %h", result0_o, exp0); end
    checks++; if (result1_o !== exp1) begin errors++; $display("FAIL special_result1: got %h want %h", result1_o, exp1); end
    end_pair();
  endtask

  task automatic test_flush();
    int n, k;
    unit_lat = 4; k = kill_cnt;
    set_lanes(1, 3'd0, 32'd11, 32'd13, 0, 3'd0, 0, 0);
    repeat (2) @(negedge clock_i);
    flush_i = 1'b1; force_done = 1'b1;
    #1;
    checks++; if (uif.kill !== 1'b1) begin errors++; $display("FAIL flush_kill: got %b want 1", uif.kill); end
    checks++; if (uif.start !== 1'b0) begin errors++; $display("FAIL flush_no_start: got %b want 0", uif.start); end
    @(negedge clock_i);
    flush_i = 1'b0; force_done = 1'b0;
    #1;
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL flush_result_kept: got %h want %h", result0_o, exp0); end
    checks++; if (exec_stall_o !== 1'b1 || uif.start !== 1'b1) begin errors++; $display("FAIL flush_reissue: stall %b start %b want 1 1", exec_stall_o, uif.start); end
    checks++; if (kill_cnt - k != 1) begin errors++; $display("FAIL flush_kill_count: got %0d want 1", kill_cnt - k); end
    wait_stall(40, n);
    exp0 = 32'd143;
    $display("txn flush: restart stall=%0d result0=%0d", n, result0_o);
    checks++; if (n != 5) begin errors++; $display("FAIL flush_restart_stall: got %0d want 5", n); end
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL flush_restart_result: got %0d want %0d", result0_o, exp0); end
    end_pair();
  endtask

  task automatic test_async_reset();
    int n, s;
    unit_lat = 4;
    set_lanes(1, 3'd0, 32'd5, 32'd5, 0, 3'd0, 0, 0);
    repeat (2) @(negedge clock_i);
    #2 reset_ni = 1'b0;
    #1;
    checks++; if (uif.start !== 1'b0 || uif.kill !== 1'b0) begin errors++; $display("FAIL areset_pulses: start %b kill %b want 0 0", uif.start, uif.kill); end
    checks++; if (uif.op !== 3'h0 || uif.a !== 32'h0 || uif.b !== 32'h0) begin errors++; $display("FAIL areset_unit_regs: op %h a %h b %h want 0", uif.op, uif.a, uif.b); end
    checks++; if (result0_o !== 32'h0 || result1_o !== 32'h0) begin errors++; $display("FAIL areset_results: r0 %h r1 %h want 0 0", result0_o, result1_o); end
    checks++; if (exec_stall_o !== 1'b1) begin errors++; $display("FAIL areset_stall: got %b want 1", exec_stall_o); end
    exp0 = 32'h0; exp1 = 32'h0;
    set_lanes(1, 3'd3, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 0, 0);
    @(negedge clock_i);
    reset_ni = 1'b1;
    s = start_cnt;
    wait_stall(40, n);
    exp0 = 32'd1;
    $display("txn areset: MULHU stall=%0d result0=%h", n, result0_o);
    checks++; if (n != 5 || start_cnt - s != 1) begin errors++; $display("FAIL areset_restart: stall %0d starts %0d want 5 1", n, start_cnt - s); end
    checks++; if (result0_o !== exp0) begin errors++; $display("FAIL areset_result: got %h want %h", result0_o, exp0); end
    end_pair();
  endtask

  task automatic test_backend_we();
    int n, s, i;
    unit_lat = 2;
    set_lanes(1, 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 3'd2, 32'hFFFF_FFF0, 32'd5);
    wait_stall(40, n);
    exp0 = ref_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    exp1 = ref_op(3'd2, 32'hFFFF_FFF0, 32'd5);
    $display("txn we_pair1: stall=%0d result0=%h result1=%h", n, result0_o, result1_o);
    checks++; if (n != 6) begin errors++; $display("FAIL we_stall1: got %0d want 6", n); end
    checks++; if (result0_o !== exp0 || result1_o !== exp1) begin errors++; $display("FAIL we_results1: got %h %h want %h %h", result0_o, result1_o, exp0, exp1); end
    s = start_cnt;
    repeat (3) @(negedge clock_i);
    checks++; if (exec_stall_o !== 1'b0 || start_cnt != s) begin errors++; $display("FAIL we_hold: stall %b starts %0d want 0 0", exec_stall_o, start_cnt - s); end
    end_pair();
    checks++; if (result0_o !== exp0 || result1_o !== exp1) begin errors++; $display("FAIL we_results_kept: got %h %h want %h %h", result0_o, result1_o, exp0, exp1); end
    i = start_log.size();
    set_lanes(1, 3'd0, 32'd9, 32'd9, 1, 3'd0, 32'd4, 32'd4);
    wait_stall(40, n);
    exp0 = 32'd81; exp1 = 32'd16;
    $display("txn we_pair2: stall=%0d result0=%0d result1=%0d", n, result0_o, result1_o);
    checks++; if (n != 6) begin errors++; $display("FAIL we_stall2: got %0d want 6", n); end
    checks++; if (start_log.size() < i + 1 || start_log[i].a !== 32'd9) begin errors++; $display("FAIL we_lane0_first: log %0d want >= %0d, first a must be 9", start_log.size(), i + 1); end
    checks++; if (result0_o !== exp0 || result1_o !== exp1) begin errors++; $display("FAIL we_results2: got %0d %0d want %0d %0d", result0_o, result1_o, exp0, exp1); end
    end_pair();
  endtask

  task automatic test_random();
    int n, s, want_n, want_starts, k;
    logic r0, r1;
    logic [2:0] o0, o1;
    logic [31:0] x0, y0, x1, y1;
    for (int it = 0; it < 30; it++) begin
      unit_lat = $urandom_range(1, 5);
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      o0 = 3'($urandom_range(0, 7)); o1 = 3'($urandom_range(0, 7));
      x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
      k = $urandom_range(0, 3);
      if (k == 0) y0 = 32'h0;
      if (k == 1) begin x1 = 32'h8000_0000; y1 = 32'hFFFF_FFFF; end
      if (k == 2) y1 = 32'h0;
      want_n = 0; want_starts = 0;
      if (r0) begin
        if (is_special(o0, x0, y0)) want_n += 1; else begin want_n += unit_lat + 1; want_starts++; end
        exp0 = ref_op(o0, x0, y0);
      end
      if (r1) begin
        if (is_special(o1, x1, y1)) want_n += 1; else begin want_n += unit_lat + 1; want_starts++; end
        exp1 = ref_op(o1, x1, y1);
      end
      s = start_cnt;
      set_lanes(r0, o0, x0, y0, r1, o1, x1, y1);
      wait_stall(60, n);
      $display("txn rand %0d: L=%0d r0=%b op0=%0d %h,%h r1=%b op1=%0d %h,%h stall=%0d res=%h,%h",
               it, unit_lat, r0, o0, x0, y0, r1, o1, x1, y1, n, result0_o, result1_o);
      checks++; if (n != want_n) begin errors++; $display("FAIL rand_stall[%0d]: got %0d want %0d", it, n, want_n); end
      checks++; if (start_cnt - s != want_starts) begin errors++; $display("FAIL rand_starts[%0d]: got %0d want %0d", it, start_cnt - s, want_starts); end
      checks++; if (result0_o !== exp0) begin errors++; $display("FAIL rand_result0[%0d]: got %h want %h", it, result0_o, exp0); end
      checks++; if (result1_o !== exp1) begin errors++; $display("FAIL rand_result1[%0d]: got %h want %h", it, result1_o, exp1); end
      end_pair();
    end
  endtask

  initial begin
    test_reset();
    test_single_mul();
    test_two_lanes();
    test_special();
    test_flush();
    test_async_reset();
    test_backend_we();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
